// File: rtl/tm_lif_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: one shared
// integrate/compare datapath visits every neuron in round-robin order.
module tm_lif_array #(
  parameter int NUM_NEURONS    = 8,
  parameter int WIDTH          = 8,
  parameter int LEAK_SHIFT     = 1,
  parameter int REFRAC_SWEEPS  = 2,
  parameter int DEFAULT_THRESH = 127,
  parameter int IDXW           = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_current,
  output logic [IDXW-1:0]        cur_idx,
  input  logic                   cfg_we,
  input  logic [IDXW-1:0]        cfg_addr,
  input  logic [WIDTH-1:0]       cfg_thresh,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   spike_valid
);
  localparam int RW = 4;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_NEURONS - 1);
  localparam logic [IDXW:0]   NCNT = (IDXW+1)'(NUM_NEURONS);

  logic [NUM_NEURONS-1:0][WIDTH-1:0] state, thresh;
  logic [NUM_NEURONS-1:0][RW-1:0]    refrac;
  logic [NUM_NEURONS-1:0]            spike_acc, spike_next;

  logic             xfer, refrac_busy, fire;
  logic [WIDTH-1:0] cur_state, sum_sat;
  logic [WIDTH:0]   sum_raw;

  // Config writes own the cycle; the input stalls while one is in flight.
  assign in_ready = !cfg_we;
  assign xfer     = in_valid && in_ready;

  assign cur_state   = state[cur_idx];
  assign sum_raw     = {1'b0, cur_state >> LEAK_SHIFT} + {1'b0, in_current};
  assign sum_sat     = sum_raw[WIDTH] ? {WIDTH{1'b1}} : sum_raw[WIDTH-1:0];
  assign refrac_busy = refrac[cur_idx] != '0;
  assign fire        = !refrac_busy && (sum_sat >= thresh[cur_idx]);

  // Vector including the bit being computed now, so the final neuron of a
  // sweep lands in spike_out on the same edge.
  always_comb begin
    spike_next          = spike_acc;
    spike_next[cur_idx] = fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= '0;
      refrac      <= '0;
      thresh      <= {NUM_NEURONS{WIDTH'(DEFAULT_THRESH)}};
      cur_idx     <= '0;
      spike_acc   <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
    end else begin
      spike_valid <= 1'b0;
      if (cfg_we && ({1'b0, cfg_addr} < NCNT))
        thresh[cfg_addr] <= cfg_thresh;
      if (xfer) begin
        spike_acc <= spike_next;
        if (refrac_busy) begin
          state[cur_idx]  <= '0;
          refrac[cur_idx] <= refrac[cur_idx] - RW'(1);
        end else if (fire) begin
          state[cur_idx]  <= '0;
          refrac[cur_idx] <= RW'(REFRAC_SWEEPS);
        end else begin
          state[cur_idx]  <= sum_sat;
        end
        if (cur_idx == LAST) begin
          cur_idx     <= '0;
          spike_out   <= spike_next;
          spike_valid <= 1'b1;
        end else begin
          cur_idx <= cur_idx + IDXW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_tm_lif_array.sv
// Scoreboard bench for tm_lif_array: driver updates a behavioural neuron
// model and queues expected sweep vectors; a monitor checks each spike_valid.
module tb_tm_lif_array;
  localparam int N = 8, W = 8, LS = 1, RS = 2, DT = 127, IW = 3;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cfg_we = 1'b0;
  logic [W-1:0]  in_current = '0, cfg_thresh = '0;
  logic [IW-1:0] cfg_addr = '0;
  wire           in_ready, spike_valid;
  wire  [IW-1:0] cur_idx;
  wire  [N-1:0]  spike_out;

  tm_lif_array #(.NUM_NEURONS(N), .WIDTH(W), .LEAK_SHIFT(LS),
                 .REFRAC_SWEEPS(RS), .DEFAULT_THRESH(DT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_current(in_current), .cur_idx(cur_idx), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_thresh(cfg_thresh), .spike_out(spike_out),
    .spike_valid(spike_valid));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int m_state[N], m_refrac[N], m_thresh[N];
  int m_idx;
  logic [N-1:0] m_acc;

  typedef struct { logic [N-1:0] vec; int due; } exp_t;
  exp_t q[$];
  exp_t e;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0; m_refrac[i] = 0; m_thresh[i] = DT;
    end
    m_idx = 0; m_acc = '0;
  endtask

  // Neuron rules in plain integer arithmetic.
  task automatic model_xfer(int cur);
    int s; bit sp;
    if (m_refrac[m_idx] > 0) begin
      m_state[m_idx] = 0; m_refrac[m_idx]--; sp = 0;
    end else begin
      s = (m_state[m_idx] >> LS) + cur;
      if (s > (1 << W) - 1) s = (1 << W) - 1;
      if (s >= m_thresh[m_idx]) begin
        sp = 1; m_state[m_idx] = 0; m_refrac[m_idx] = RS;
      end else begin
        sp = 0; m_state[m_idx] = s;
      end
    end
    m_acc[m_idx] = sp;
    if (m_idx == N - 1) begin
      q.push_back('{m_acc, cyc + 1});
      m_idx = 0;
    end else m_idx++;
  endtask

  task automatic step(bit v, int cur, bit we = 0, int addr = 0, int th = 0);
    @(negedge clk);
    chk("cur_idx", cur_idx, m_idx);
    in_valid = v; in_current = cur[W-1:0]; cfg_we = we;
    cfg_addr = addr[IW-1:0]; cfg_thresh = th[W-1:0];
    #1;
    chk("in_ready", in_ready, !we);
    if (we) m_thresh[addr] = th;
    else if (v) model_xfer(cur);
  endtask

  task automatic sweep(input int cur [N]);
    for (int i = 0; i < N; i++) step(1, cur[i]);
    step(0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
    model_reset();
    q.delete();
    repeat (2) @(negedge clk);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_spike_out", spike_out, 0);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
  endtask

  // Monitor: every spike_valid must match the queue head, on its due cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (spike_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL spike_unexpected: got spike_valid=1 vec=0x%0h expected no pulse (cyc=%0d)", spike_out, cyc);
      end else begin
        e = q.pop_front();
        chk("spike_out", spike_out, e.vec);
        chk("spike_latency", cyc, e.due);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      total++; bad++;
      $display("FAIL spike_missing: got no pulse expected vec=0x%0h at cyc=%0d", q[0].vec, q[0].due);
      e = q.pop_front();
    end
  end

  initial begin
    int z[N], c[N];
    logic [N-1:0] pat;
    for (int i = 0; i < N; i++) z[i] = 0;

    do_reset();
    sweep(z);
    chk("zero_sweep", spike_out, 0);

    // Neuron 0 integrates 64 per sweep and fires on sweep 7.
    c = z; c[0] = 64;
    for (int s = 1; s <= 7; s++) begin
      sweep(c);
      chk("leak_sweep", spike_out, (s == 7) ? 1 : 0);
    end

    // Refractory pattern on neuron 3.
    do_reset();
    c = z; c[3] = 255;
    pat = 8'b0010_0100;
    for (int s = 0; s < 6; s++) begin
      sweep(c);
      chk("refrac_bit3", spike_out[3], pat[5-s]);
    end

    // Saturation: 254>>1 + 255 would wrap to 126 without clamping.
    do_reset();
    step(0, 0, 1, 2, 255);
    c = z; c[2] = 254; sweep(c);
    chk("sat_pre", spike_out, 0);
    c[2] = 255; sweep(c);
    chk("sat_fire", spike_out, 8'h04);

    // Config write collides with a valid input; neuron 5 fires in the same sweep.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0);
    step(1, 10, 1, 5, 10);
    step(1, 10);
    chk("cfg_hold_idx", m_idx, 6);
    step(1, 0); step(1, 0); step(0, 0);
    chk("cfg_fire", spike_out, 8'h20);

    // Reset mid-sweep discards the partial sweep.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 200);
    do_reset();
    c = z; c[0] = 100; sweep(c);
    chk("post_reset_sweep", spike_out, 0);

    // Randomized traffic including stalls and threshold rewrites.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0)
        step($urandom_range(0, 1), $urandom_range(0, 255), 1,
             $urandom_range(0, N - 1), $urandom_range(0, 255));
      else
        step($urandom_range(0, 9) < 7, $urandom_range(0, 255));
    end
    repeat (3) step(0, 0);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tm_lif_array.md
# tm_lif_array

Parametrised, time-multiplexed leaky integrate-and-fire neuron array. One shared integrate/compare datapath serves NUM_NEURONS neurons in round-robin order. Each neuron has its own membrane state, programmable threshold and refractory counter. Input currents arrive serially over a valid/ready handshake, one per neuron per sweep. The spike vector for a full sweep is published as a registered word with a one-cycle valid strobe. The block sits between the input current encoder and the spike router.

## Interface
- NUM_NEURONS, 8: neurons per sweep, 2..256
- WIDTH, 8: bits of current, membrane state and threshold
- LEAK_SHIFT, 1: membrane leak as a right shift of state, 0..WIDTH-1
- REFRAC_SWEEPS, 2: sweeps a neuron stays silent after firing, 0..15
- DEFAULT_THRESH, 127: threshold loaded into every neuron at reset
- IDXW, derived as $clog2(NUM_NEURONS): width of the index fields

- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  in_current is valid
- in_ready  out  1  block accepts in_current this cycle
- in_current  in  WIDTH  unsigned input current for neuron cur_idx
- cur_idx  out  IDXW  index of the neuron the next accepted current feeds
- cfg_we  in  1  threshold write strobe
- cfg_addr  in  IDXW  neuron index for the threshold write
- cfg_thresh  in  WIDTH  new threshold value
- spike_out  out  NUM_NEURONS  spike vector of the last completed sweep; bit i is neuron i
- spike_valid  out  1  one-cycle pulse when spike_out updates

## Operation
- in_ready is !cfg_we, combinational. A config write takes priority and stalls the input for that cycle.
- Handshake: the transfer happens on a cycle with in_valid && in_ready. in_current must stay stable while in_valid is high and in_ready is low.
- On each transfer for neuron i = cur_idx:
  - If refrac[i] != 0: state[i] <= 0, refrac[i] <= refrac[i]-1, spike bit i = 0.
  - Otherwise: sum = (state[i] >> LEAK_SHIFT) + in_current, computed in WIDTH+1 bits and saturated to 2^WIDTH-1.
  - If sum >= thresh[i], unsigned compare: spike bit i = 1, state[i] <= 0, refrac[i] <= REFRAC_SWEEPS.
  - Otherwise: spike bit i = 0, state[i] <= sum.
- Spike bits collect in an internal vector. cur_idx increments on every transfer and wraps from NUM_NEURONS-1 to 0.
- Sweep completion is the transfer for neuron NUM_NEURONS-1. On the next edge, spike_out loads the full vector, including bit NUM_NEURONS-1. spike_valid pulses for exactly one cycle.
- Threshold write: when cfg_we=1, thresh[cfg_addr] <= cfg_thresh. A cfg_addr >= NUM_NEURONS is ignored. A write takes effect from the next transfer for that neuron.
- Threshold 0 means the neuron fires on every non-refractory transfer.

## Timing
- Reset values:
  - state 0 and refrac 0 for all neurons; thresh DEFAULT_THRESH for all neurons
  - cur_idx 0, spike_out 0, spike_valid 0
  - in_ready follows !cfg_we
- Throughput: one neuron update per cycle. A full sweep takes NUM_NEURONS accepted transfers.
- Latency: spike_out/spike_valid are registered one cycle after the final transfer of a sweep.
- Stall with in_valid=0: no state change, cur_idx held, spike_valid stays 0.
- Back-to-back sweeps: spike_valid may pulse every NUM_NEURONS cycles with no bubble.
- Reset mid-sweep: the partial spike vector is discarded, cur_idx returns to 0, and spike_valid does not pulse.

## Test plan
- Reset, then drive in_current=0 for 8 transfers -> spike_valid pulses once, one cycle after the 8th transfer; spike_out=0x00; all states remain 0.
- Neuron 0 gets current 64 every sweep, others 0, thresh 127, LEAK_SHIFT 1:
  - state sequence 64, 96, 112, 120, 124, 126, then sum 127 fires -> spike_out=0x01 on sweep 7 only.
- With REFRAC_SWEEPS=2, neuron 3 gets current 255 every sweep -> spike_out bit 3 pattern across sweeps is 1,0,0,1,0,0.
- Current 200 into state 200 with LEAK_SHIFT 0 and thresh 255 -> sum saturates to 255 and fires; no wrap to 144.
- cfg_we with addr 5, thresh 10, asserted alongside in_valid -> in_ready=0 that cycle and cur_idx holds; neuron 5 then fires on current 10 in the same sweep.
- Deassert rst_n after 4 transfers of a sweep -> spike_valid never pulses, cur_idx=0 at release, and the next full sweep behaves as from cold reset.
